// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write frontend: entry tags and FSM state encoding.
package fifo_pkg;

  localparam logic [1:0] TAG_DATA  = 2'b00;
  localparam logic [1:0] TAG_LAST  = 2'b01;
  localparam logic [1:0] TAG_ABORT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } fsm_state_t;

  function automatic logic [1:0] byte_tag(input logic last);
    return last ? TAG_LAST : TAG_DATA;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer with push/pop and occupancy count.
// An empty buffer presents zero on o_data.
module fifo_skid_buf #(
  parameter int WIDTH = 10
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full buffer is legal when the head leaves on the same edge.
  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_data  = (r_count == 2'd0) ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fifo_wr_frontend.sv
// Frame-aware write frontend: tags upstream bytes, converts aborts into markers and
// feeds the async FIFO write port. Counters exist only with FIFO_WR_FRONTEND_STATS_EN.
module fifo_wr_frontend
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             abort,
  input  logic             wfull,
  input  logic             awfull,
  output logic             winc,
  output logic [DSIZE+1:0] wdata,
  output logic [7:0]       frames_written,
  output logic [7:0]       drop_cnt
);

  localparam int EW = DSIZE + 2;

  fsm_state_t      r_state;
  logic            r_pend;
  logic            r_s_ready;

  logic [1:0]      w_count;
  logic [EW-1:0]   w_head;
  logic            w_pop;
  logic            w_accept;
  logic            w_last_acc;
  logic            w_abort_now;
  logic            w_byte_push;
  logic            w_space;
  logic            w_mark_push;
  logic            w_push;
  logic [EW-1:0]   w_push_data;
  logic [1:0]      w_count_nxt;
  logic            w_pend_nxt;
  logic            w_drop_nxt;

  assign w_pop       = (w_count != 2'd0) && !wfull;
  assign w_accept    = s_valid && r_s_ready;
  assign w_last_acc  = w_accept && s_last;
  assign w_abort_now = abort && (r_state == FRAME);

  // An abort in FRAME swallows any byte accepted on the same edge.
  assign w_byte_push = w_accept && (r_state != DROP) && !w_abort_now;
  assign w_space     = (w_count != 2'd2) || w_pop;
  assign w_mark_push = (r_pend || w_abort_now) && w_space;
  assign w_push      = w_byte_push || w_mark_push;
  assign w_push_data = w_mark_push ? {TAG_ABORT, {DSIZE{1'b0}}}
                                   : {byte_tag(s_last), s_data};

  assign w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_pend_nxt  = (r_pend || w_abort_now) && !w_space;
  assign w_drop_nxt  = !w_last_acc && ((r_state == DROP) || w_abort_now);

  fifo_skid_buf #(
    .WIDTH (EW)
  ) u_skid (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // A pending marker blocks upstream so no later byte can overtake it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= IDLE;
      r_pend    <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_s_ready <= !w_pend_nxt && (w_drop_nxt || ((w_count_nxt != 2'd2) && !awfull));
      case (r_state)
        IDLE: begin
          if (w_accept && !s_last) r_state <= FRAME;
        end
        FRAME: begin
          if (w_abort_now)     r_state <= w_last_acc ? IDLE : DROP;
          else if (w_last_acc) r_state <= IDLE;
        end
        DROP: begin
          if (w_last_acc) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign winc    = w_pop;
  assign wdata   = w_head;

`ifdef FIFO_WR_FRONTEND_STATS_EN
  logic [7:0] r_frames;
  logic [7:0] r_drops;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_frames <= 8'd0;
      r_drops  <= 8'd0;
    end else if (w_pop) begin
      if (w_head[EW-1:DSIZE] == TAG_LAST)  r_frames <= r_frames + 8'd1;
      if (w_head[EW-1:DSIZE] == TAG_ABORT) r_drops  <= r_drops + 8'd1;
    end
  end

  assign frames_written = r_frames;
  assign drop_cnt       = r_drops;
`else
  assign frames_written = 8'd0;
  assign drop_cnt       = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Bench for fifo_wr_frontend: directed frames/aborts plus random traffic against a
// transaction-level model of the expected FIFO write stream.
module tb_fifo_wr_frontend;
  import fifo_pkg::*;

`ifdef FIFO_WR_FRONTEND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       abort = 1'b0;
  logic       wfull = 1'b0;
  logic       awfull = 1'b0;
  logic       winc;
  logic [9:0] wdata;
  logic [7:0] frames_written;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_en = 1'b0;

  // Model state: expected write stream and frame mode (0 idle, 1 in frame, 2 dropping)
  logic [9:0] exp_q[$];
  int         m_mode = 0;
  logic [7:0] m_frames = 8'd0;
  logic [7:0] m_drops = 8'd0;
  logic       rdy_exp = 1'b0;

  fifo_wr_frontend #(.DSIZE(8)) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .abort          (abort),
    .wfull          (wfull),
    .awfull         (awfull),
    .winc           (winc),
    .wdata          (wdata),
    .frames_written (frames_written),
    .drop_cnt       (drop_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: observes each upcoming edge at the preceding negedge.
  always @(negedge wclk) begin
    logic       acc;
    logic       exp_winc;
    logic [9:0] e;
    int         sz;
    if (!wrst_n) begin
      exp_q.delete();
      m_mode   = 0;
      m_frames = 8'd0;
      m_drops  = 8'd0;
      rdy_exp  = 1'b0;
    end else begin
      check("s_ready", {31'd0, s_ready}, {31'd0, rdy_exp});
      exp_winc = (exp_q.size() > 0) && !wfull;
      check("winc", {31'd0, winc}, {31'd0, exp_winc});
      check("frames_written", {24'd0, frames_written}, {24'd0, STATS ? m_frames : 8'd0});
      check("drop_cnt", {24'd0, drop_cnt}, {24'd0, STATS ? m_drops : 8'd0});
      if (winc && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wdata", {22'd0, wdata}, {22'd0, e});
        if (e[9:8] == 2'b01) m_frames = m_frames + 8'd1;
        if (e[9:8] == 2'b10) m_drops  = m_drops + 8'd1;
      end
      acc = s_valid && s_ready;
      if (abort && m_mode == 1) begin
        exp_q.push_back(10'h200);
        m_mode = (acc && s_last) ? 0 : 2;
      end else if (acc) begin
        if (m_mode == 2) begin
          if (s_last) m_mode = 0;
        end else begin
          exp_q.push_back({1'b0, s_last, s_data});
          m_mode = s_last ? 0 : 1;
        end
      end
      // Readiness for the next edge: marker waiting -> 0; dropping -> 1; else room and not almost full
      sz = exp_q.size();
      if (sz > 2)           rdy_exp = 1'b0;
      else if (m_mode == 2) rdy_exp = 1'b1;
      else                  rdy_exp = (sz < 2) && !awfull;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wclk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic ab);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last; abort = ab;
    for (int k = 0; k < 200; k++) begin
      @(negedge wclk);
      acc = s_ready;
      @(posedge wclk); #1;
      abort = 1'b0;
      if (acc) break;
    end
    check("accept", {31'd0, acc}, 32'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge wclk); #1;
    abort = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge wclk); #1;
    end
    check("drain", exp_q.size(), 32'd0);
    cycles(2);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    s_valid = 1'b0; abort = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_winc", {31'd0, winc}, 32'd0);
    check("rst_wdata", {22'd0, wdata}, 32'd0);
    check("rst_frames", {24'd0, frames_written}, 32'd0);
    check("rst_drops", {24'd0, drop_cnt}, 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    cycles(2);
    wrst_n = 1'b1;
    cycles(1);
  endtask

  // Background full/almost-full churn for the random phase
  initial begin
    forever begin
      @(posedge wclk); #1;
      if (rnd_en) begin
        wfull  = ($urandom_range(0, 2) == 0);
        awfull = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    cycles(3);
    do_reset();

    // Plain three-byte frame into an empty FIFO
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hB2, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    drain();
    check("frame1_count", {24'd0, frames_written}, {24'd0, STATS ? 8'd1 : 8'd0});

    // FIFO full mid-frame: two bytes buffered, upstream stalled
    wfull = 1'b1;
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    cycles(5);
    check("stall_ready", {31'd0, s_ready}, 32'd0);
    check("stall_winc", {31'd0, winc}, 32'd0);
    wfull = 1'b0;
    send_byte(8'h33, 1'b1, 1'b0);
    drain();

    // Abort after two bytes; remaining bytes of the frame are discarded
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    pulse_abort();
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    drain();
    check("abort_state", 32'(dut.r_state), 32'(IDLE));
    check("abort_drops", {24'd0, drop_cnt}, {24'd0, STATS ? 8'd1 : 8'd0});

    // Abort on the same edge as the accepted last byte
    send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, 1'b1);
    drain();
    check("coinc_state", 32'(dut.r_state), 32'(IDLE));

    // Abort with the buffer full and FIFO full: marker waits behind two bytes
    wfull = 1'b1;
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    pulse_abort();
    cycles(2);
    check("pend_ready", {31'd0, s_ready}, 32'd0);
    check("pend_flag", {31'd0, dut.r_pend}, 32'd1);
    wfull = 1'b0;
    drain();
    send_byte(8'h70, 1'b1, 1'b0);
    drain();

    // Random frames with random aborts and FIFO back-pressure
    rnd_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++)
        send_byte(8'($urandom_range(0, 255)), (b == len - 1), ($urandom_range(0, 9) == 0));
    end
    rnd_en = 1'b0;
    cycles(1);
    wfull = 1'b0; awfull = 1'b0;
    drain();

    // 256 one-byte frames from a clean counter: wraps back to zero
    do_reset();
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1, 1'b0);
    drain();
    check("wrap_frames", {24'd0, frames_written}, 32'd0);

    // Reset in the middle of a buffered frame: nothing may reach the FIFO afterwards
    wfull = 1'b1;
    send_byte(8'h81, 1'b0, 1'b0);
    send_byte(8'h82, 1'b0, 1'b0);
    do_reset();
    wfull = 1'b0;
    cycles(5);
    check("post_rst_winc", {31'd0, winc}, 32'd0);
    check("post_rst_state", 32'(dut.r_state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_frontend.md
FIFO_WR_FRONTEND -- requirements
Module: fifo_wr_frontend

Interface
REQ-001 SHALL have parameter DSIZE, default 8, payload byte width.
REQ-002 SHALL have ports, clock and reset first:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream byte valid
- s_data  in  DSIZE  upstream byte
- s_last  in  1  final byte of frame
- s_ready  out  1  frontend accepts byte
- abort  in  1  single-cycle pulse; cancel current frame
- wfull  in  1  FIFO full, from write-pointer logic
- awfull  in  1  FIFO almost full (one slot left)
- winc  out  1  FIFO write strobe
- wdata  out  DSIZE+2  {tag[1:0], payload}
- frames_written  out  8  completed frames counter
- drop_cnt  out  8  aborted frames counter
REQ-003 SHALL use reset wrst_n, asynchronous, active-low, and clock wclk.

Function
REQ-004 SHALL accept a byte on any wclk edge with s_valid && s_ready.
REQ-005 SHALL hold accepted entries in a 2-entry skid buffer, in order; s_ready SHALL be registered, high iff buffer occupancy after the current edge is < 2 and awfull is low.
REQ-006 SHALL drive winc combinationally high iff the buffer is non-empty and wfull is low; wdata SHALL be the buffer head; head pops on the same edge.
REQ-007 Tags: 00 data byte, 01 last byte of frame, 10 abort marker (payload 0), 11 unused.
REQ-008 SHALL have FSM states IDLE, FRAME, DROP; reset state IDLE.
REQ-009 IDLE->FRAME on an accepted byte with s_last=0; an accepted byte with s_last=1 in IDLE SHALL be a one-byte frame, stay IDLE.
REQ-010 FRAME->IDLE on an accepted byte with s_last=1 (tagged 01).
REQ-011 abort in FRAME SHALL enqueue one abort marker and go to DROP; abort in IDLE or DROP SHALL be ignored.
REQ-012 In DROP, s_ready SHALL be 1 and bytes SHALL be discarded without enqueue; DROP->IDLE on an accepted byte with s_last=1.
REQ-013 Abort coinciding with an accepted s_last byte SHALL take precedence: byte dropped, marker enqueued, next state IDLE.
REQ-014 If the marker cannot enter the buffer (buffer full), it SHALL be held pending and enqueued on the first free slot before any later byte; s_ready low while pending.
REQ-015 Latency: byte accepted at edge N is presented on wdata in cycle N+1 at the earliest.
REQ-016 Counters SHALL increment when the tag-01 entry (frames_written) or tag-10 entry (drop_cnt) is written with winc; both wrap 255->0.
REQ-017 No entry SHALL ever be lost or duplicated while wfull toggles.

Reset
REQ-018 On wrst_n low: buffer empty, state IDLE, pending marker cleared, s_ready=0, winc=0, wdata=0, counters=0.
REQ-019 s_ready SHALL first rise on the first wclk edge after reset release.
REQ-020 Reset mid-frame SHALL discard all buffered entries with no marker written.

Configuration
REQ-021 Macro FIFO_WR_FRONTEND_STATS_EN: defined -> counters per REQ-016; undefined -> frames_written and drop_cnt tied to 0, no counter flops.

Structure
REQ-022 Shared package fifo_pkg SHALL hold tag constants (TAG_DATA, TAG_LAST, TAG_ABORT) and FSM state encoding.
REQ-023 Skid buffer SHALL be sub-module fifo_skid_buf (push/pop/count, 2 entries, width DSIZE+2).

Verification
REQ-024 Bench SHALL cover:
- Frame 0xA1,0xB2,0xC3(last), FIFO empty -> wdata 0x0A1,0x0B2,0x1C3; frames_written=1.
- wfull held high 5 cycles mid-frame -> winc 0; s_ready low after 2 buffered; all bytes delivered in order after release.
- Abort after 2 bytes, 3 more bytes incl. last -> marker 0x200 written, trailing bytes dropped; drop_cnt=1; state IDLE.
- Abort coincident with accepted last byte 0x55 -> 0x155 never written, 0x200 written.
- Abort with buffer full and wfull=1 -> marker pending; written after the two buffered bytes once wfull falls.
- 256 one-byte frames -> frames_written wraps to 0; wrst_n pulse mid-frame -> all outputs per REQ-018.
